// File: rtl/rr_decoder_arbiter.sv
// Four-client round-robin arbiter with 2-bit owner index decoded to a one-hot grant and bounded hold time.
// Latency: grant registered 1 cycle after request sampled in IDLE; en low zeroes gnt combinationally.
// Backpressure: owner keeps grant until done, req drop, en low or MAX_HOLD cycles; at least one IDLE cycle between grants.
module rr_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    pick_idx;
  logic [1:0]    cand;
  logic          pick_vld;
  logic          cause_en, cause_done, cause_req, cause_hold, release_now;

  // Round-robin search starting at ptr; descending loop lets the closest offset win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Release causes for the current owner, listed in priority order.
  always_comb begin
    cause_en    = ~en;
    cause_done  = done;
    cause_req   = ~req[idx_q];
    cause_hold  = (hold_cnt_q == HOLD_LAST);
    release_now = cause_en | cause_done | cause_req | cause_hold;
  end

  // Next-state logic: IDLE arbitrates, GRANT counts hold time and releases.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          idx_d      = pick_idx;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = idx_q + 2'd1;
          state_d   = IDLE;
          // Timeout only flags a release caused by nothing but the hold limit.
          timeout_d = cause_hold & ~(cause_en | cause_done | cause_req);
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset returns to IDLE with pointer and owner at client 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      idx_q      <= 2'd0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Output decode; en gates the grant immediately, ahead of the state change.
  always_comb begin
    busy    = (state_q == GRANT);
    gnt_idx = idx_q;
    timeout = timeout_q;
    gnt     = (busy && en) ? (4'b0001 << idx_q) : 4'b0000;
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Testbench for rr_decoder_arbiter: behavioural ownership model plus directed scenarios.
// Inputs change 2 time units after the rising edge; outputs compared on the falling edge.
// Literal checks inside the directed sequence pin the model's expectations.
module tb_rr_decoder_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Ownership model: who owns, for how many cycles, and where the next search starts.
  int m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_held = 0;
  int m_to   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (m_busy != 0) begin
      bit r_en, r_done, r_req, r_hold;
      r_en   = (en == 1'b0);
      r_done = (done == 1'b1);
      r_req  = (req[m_idx] == 1'b0);
      r_hold = (m_held == MAX_HOLD);
      m_to   = (r_hold && !(r_en || r_done || r_req)) ? 1 : 0;
      if (r_en || r_done || r_req || r_hold) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 4;
      end else begin
        m_held = m_held + 1;
      end
    end else begin
      m_to = 0;
      if (en == 1'b1 && req != 4'b0000) begin
        bit found;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            found  = 1;
            m_idx  = (m_ptr + k) % 4;
          end
        end
        m_busy = 1;
        m_held = 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [3:0] exp_gnt;
    exp_gnt = (m_busy != 0 && en == 1'b1) ? (4'b0001 << m_idx) : 4'b0000;
    check("model_gnt", {4'b0, gnt}, {4'b0, exp_gnt});
    check("model_idx", {6'b0, gnt_idx}, 8'(m_idx));
    check("model_busy", {7'b0, busy}, 8'(m_busy));
    check("model_timeout", {7'b0, timeout}, 8'(m_to));
  end

  logic [3:0] rot [4];

  initial begin
    rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;
    rst_n = 1'b0; en = 1'b0; req = 4'b0000; done = 1'b0;
    #3;
    check("reset_gnt", {4'b0, gnt}, 8'h00);
    check("reset_idx", {6'b0, gnt_idx}, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    check("reset_timeout", {7'b0, timeout}, 8'h00);
    step(1);
    rst_n = 1'b1;

    // Reset mid-grant: client 2 owns, then asynchronous reset.
    en = 1'b1; req = 4'b0100;
    step(1);
    check("c2_grant", {4'b0, gnt}, 8'h04);
    check("c2_idx", {6'b0, gnt_idx}, 8'h02);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", {4'b0, gnt}, 8'h00);
    check("arst_busy", {7'b0, busy}, 8'h00);
    check("arst_idx", {6'b0, gnt_idx}, 8'h00);
    step(1);
    rst_n = 1'b1; req = 4'b1111;
    step(1);
    check("post_reset_c0", {4'b0, gnt}, 8'h01);

    // Rotation with a one-cycle done pulse per grant.
    for (int i = 0; i < 4; i++) begin
      done = 1'b1;
      step(1);
      check("rot_gap", {4'b0, gnt}, 8'h00);
      done = 1'b0;
      step(1);
      check("rot_gnt", {4'b0, gnt}, {4'b0, rot[i]});
    end

    // Wrap search: client 1 releases, ptr=2, req=0011 selects client 0.
    req = 4'b0010;
    step(1);
    check("drop_busy", {7'b0, busy}, 8'h00);
    step(1);
    check("c1_grant", {4'b0, gnt}, 8'h02);
    done = 1'b1;
    step(1);
    done = 1'b0; req = 4'b0011;
    step(1);
    check("wrap_gnt", {4'b0, gnt}, 8'h01);
    check("wrap_idx", {6'b0, gnt_idx}, 8'h00);

    // Hold limit: client 2 keeps req for MAX_HOLD cycles.
    req = 4'b0100;
    step(2);
    check("hold_c1", {4'b0, gnt}, 8'h04);
    for (int i = 2; i <= MAX_HOLD; i++) begin
      step(1);
      check("hold_gnt", {4'b0, gnt}, 8'h04);
    end
    step(1);
    check("to_gnt", {4'b0, gnt}, 8'h00);
    check("to_pulse", {7'b0, timeout}, 8'h01);
    step(1);
    check("to_regrant", {4'b0, gnt}, 8'h04);
    check("to_clear", {7'b0, timeout}, 8'h00);

    // Enable revoke while client 3 owns.
    req = 4'b1000;
    step(2);
    check("c3_grant", {4'b0, gnt}, 8'h08);
    en = 1'b0;
    #1;
    check("en_comb_gnt", {4'b0, gnt}, 8'h00);
    check("en_comb_busy", {7'b0, busy}, 8'h01);
    step(1);
    check("en_busy", {7'b0, busy}, 8'h00);
    check("en_timeout", {7'b0, timeout}, 8'h00);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("en_low_nogrant", {4'b0, gnt}, 8'h00);
    end
    en = 1'b1;
    step(1);
    check("en_ptr_kept", {4'b0, gnt}, 8'h01);

    // Simultaneous done, req drop and hold limit on one edge.
    req = 4'b0001;
    step(MAX_HOLD - 1);
    check("sim_still_owner", {4'b0, gnt}, 8'h01);
    done = 1'b1; req = 4'b0000;
    step(1);
    check("sim_busy", {7'b0, busy}, 8'h00);
    check("sim_timeout", {7'b0, timeout}, 8'h00);
    done = 1'b0; req = 4'b1111;
    step(1);
    check("sim_next_gnt", {4'b0, gnt}, 8'h02);
    check("sim_next_idx", {6'b0, gnt_idx}, 8'h01);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
